// File: rtl/uart_fifo_mmio.sv
// Memory-mapped full-duplex UART with TX/RX FIFOs, parity, stop-bit control,
// sticky W1C error flags and a maskable level interrupt.
module uart_fifo_mmio #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9_600,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    input  logic        Select,
    input  logic        Write,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
    localparam logic [31:0]   DIV_RST  = 32'(CLK_FREQ / BAUD_RATE);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

    // Both FSMs: IDLE wait | START start bit | DATA char bits | PARITY | STOP
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [2:0] addr;
    logic       wr, rd, unused_addr;
    assign addr        = Address[2:0];
    assign wr          = Select & Write;
    assign rd          = Select & ~Write;
    assign unused_addr = ^Address[31:3];

    logic        tx_en, rx_en, two_stop, par_err, frm_err, ovr;
    logic [1:0]  parity;
    logic [2:0]  ie;
    logic [31:0] baud_div, rdata, status;

    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic [DATA_BITS-1:0] tx_head, rx_head;

    state_t tx_state, rx_state;
    logic [31:0] tx_tmr, tx_div, rx_tmr, rx_div;
    logic [DATA_BITS-1:0] tx_sh, rx_sh;
    logic [3:0] tx_bit, rx_bit;
    logic tx_par_en, tx_par_bit, tx_two, tx_stop2;
    logic rx_s1, rx_s2, rx_prev, rx_par_en, rx_par_odd, rx_pbit;

    logic tx_flush, rx_flush, tx_push, tx_pop, rx_push, rx_pop;
    logic tx_busy, tx_last_stop, rx_done, rx_par_bad, w1c_status;

    assign tx_head      = tx_mem[tx_rp];
    assign rx_head      = rx_mem[rx_rp];
    assign tx_busy      = (tx_state != S_IDLE);
    assign tx_flush     = wr && addr == 3'd0 && DataIn[5];
    assign rx_flush     = wr && addr == 3'd0 && DataIn[6];
    assign w1c_status   = wr && addr == 3'd1;
    assign tx_push      = wr && addr == 3'd2 && tx_cnt != FULL;
    assign rx_pop       = rd && addr == 3'd3 && rx_cnt != '0;
    assign tx_last_stop = tx_state == S_STOP && tx_tmr == '0 && (!tx_two || tx_stop2);
    // Popping out of the last stop bit chains frames with no idle gap.
    assign tx_pop       = tx_en && tx_cnt != '0 && (tx_state == S_IDLE || tx_last_stop);
    assign rx_done      = rx_state == S_STOP && rx_tmr == '0;
    assign rx_push      = rx_done && rx_cnt != FULL;
    assign rx_par_bad   = rx_par_en && (rx_pbit != (^rx_sh ^ rx_par_odd));

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= DataIn[DATA_BITS-1:0];
        if (rx_push) rx_mem[rx_wp] <= rx_sh;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
            rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
        end else begin
            if (tx_flush) begin
                tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
            end else begin
                if (tx_push) tx_wp <= tx_wp + AW'(1);
                if (tx_pop)  tx_rp <= tx_rp + AW'(1);
                tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
            end
            if (rx_flush) begin
                rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
            end else begin
                if (rx_push) rx_wp <= rx_wp + AW'(1);
                if (rx_pop)  rx_rp <= rx_rp + AW'(1);
                rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= S_IDLE; tx <= 1'b1; tx_tmr <= '0; tx_div <= '0; tx_sh <= '0;
            tx_bit <= '0; tx_par_en <= 1'b0; tx_par_bit <= 1'b0; tx_two <= 1'b0; tx_stop2 <= 1'b0;
        end else if (tx_pop) begin
            tx_state   <= S_START;
            tx         <= 1'b0;
            tx_tmr     <= baud_div - 32'd1;
            tx_div     <= baud_div;
            tx_sh      <= tx_head;
            tx_bit     <= '0;
            tx_par_en  <= parity == 2'b01 || parity == 2'b10;
            tx_par_bit <= ^tx_head ^ parity[1];
            tx_two     <= two_stop;
            tx_stop2   <= 1'b0;
        end else if (tx_state != S_IDLE) begin
            if (tx_tmr != '0) begin
                tx_tmr <= tx_tmr - 32'd1;
            end else begin
                tx_tmr <= tx_div - 32'd1;
                case (tx_state)
                    S_START: begin
                        tx <= tx_sh[0]; tx_sh <= tx_sh >> 1; tx_state <= S_DATA;
                    end
                    S_DATA: begin
                        if (tx_bit == LAST_BIT) begin
                            tx       <= tx_par_en ? tx_par_bit : 1'b1;
                            tx_state <= tx_par_en ? S_PARITY : S_STOP;
                        end else begin
                            tx <= tx_sh[0]; tx_sh <= tx_sh >> 1; tx_bit <= tx_bit + 4'd1;
                        end
                    end
                    S_PARITY: begin
                        tx <= 1'b1; tx_state <= S_STOP;
                    end
                    default: begin
                        if (tx_two && !tx_stop2) tx_stop2 <= 1'b1;
                        else                      tx_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1; rx_state <= S_IDLE;
            rx_tmr <= '0; rx_div <= '0; rx_sh <= '0; rx_bit <= '0;
            rx_par_en <= 1'b0; rx_par_odd <= 1'b0; rx_pbit <= 1'b0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            if (rx_state == S_IDLE) begin
                if (rx_en && rx_prev && !rx_s2) begin
                    rx_state   <= S_START;
                    rx_tmr     <= (baud_div >> 1) - 32'd1;
                    rx_div     <= baud_div;
                    rx_bit     <= '0;
                    rx_par_en  <= parity == 2'b01 || parity == 2'b10;
                    rx_par_odd <= parity[1];
                end
            end else if (rx_tmr != '0) begin
                rx_tmr <= rx_tmr - 32'd1;
            end else begin
                rx_tmr <= rx_div - 32'd1;
                case (rx_state)
                    S_START:  rx_state <= rx_s2 ? S_IDLE : S_DATA;
                    S_DATA: begin
                        rx_sh  <= {rx_s2, rx_sh[DATA_BITS-1:1]};
                        rx_bit <= rx_bit + 4'd1;
                        if (rx_bit == LAST_BIT) rx_state <= rx_par_en ? S_PARITY : S_STOP;
                    end
                    S_PARITY: begin
                        rx_pbit <= rx_s2; rx_state <= S_STOP;
                    end
                    default:  rx_state <= S_IDLE;
                endcase
            end
        end
    end

    assign status = {8'd0, 8'(rx_cnt), 8'(tx_cnt), ovr, frm_err, par_err, tx_busy,
                     rx_cnt == '0, rx_cnt == FULL, tx_cnt == '0, tx_cnt == FULL};

    always_comb begin
        rdata = '0;
        case (addr)
            3'd0: rdata = {21'd0, ie, 3'd0, two_stop, parity, rx_en, tx_en};
            3'd1: rdata = status;
            3'd3: rdata = (rx_cnt != '0) ? 32'(rx_head) : 32'd0;
            3'd4: rdata = baud_div;
            default: rdata = '0;
        endcase
    end

    // Hardware set is OR-ed in after the clear so a same-cycle event survives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_en <= 1'b0; rx_en <= 1'b0; parity <= '0; two_stop <= 1'b0; ie <= '0;
            baud_div <= DIV_RST; par_err <= 1'b0; frm_err <= 1'b0; ovr <= 1'b0;
            DataOut <= '0; irq <= 1'b0;
        end else begin
            if (wr && addr == 3'd0) begin
                tx_en    <= DataIn[0];
                rx_en    <= DataIn[1];
                parity   <= DataIn[3:2];
                two_stop <= DataIn[4];
                ie       <= DataIn[10:8];
            end
            if (wr && addr == 3'd4) baud_div <= (DataIn < 32'd4) ? 32'd4 : DataIn;
            par_err <= (rx_done & rx_par_bad)      | (par_err & ~(w1c_status & DataIn[5]));
            frm_err <= (rx_done & ~rx_s2)          | (frm_err & ~(w1c_status & DataIn[6]));
            ovr     <= (rx_done & rx_cnt == FULL)  | (ovr     & ~(w1c_status & DataIn[7]));
            if (rd) DataOut <= rdata;
            irq <= (ie[0] & rx_cnt != '0) | (ie[1] & tx_cnt == '0 & ~tx_busy)
                 | (ie[2] & (par_err | frm_err | ovr));
        end
    end
endmodule

// File: tb/tb_uart_fifo_mmio.sv
// Self-checking bench for uart_fifo_mmio: frame-level model of the serial line
// plus a queue model of the RX FIFO, driven with random characters and modes.
module tb_uart_fifo_mmio;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] DataIn = '0;
    logic [31:0] DataOut;
    logic        Select = 1'b0;
    logic        Write = 1'b0;
    logic        rx, tx, irq;
    logic        rx_drv = 1'b1;
    logic        loop = 1'b0;

    int tests = 0;
    int fails = 0;
    logic [7:0] tx_bytes[$];
    logic [7:0] rx_model[$];

    assign rx = loop ? tx : rx_drv;
    always #5 clk = ~clk;

    uart_fifo_mmio dut (
        .clk(clk), .rst(rst), .Address(Address), .DataIn(DataIn), .DataOut(DataOut),
        .Select(Select), .Write(Write), .rx(rx), .tx(tx), .irq(irq)
    );

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        Select = 1'b1; Write = 1'b1; Address = {29'd0, a}; DataIn = d;
        @(negedge clk);
        Select = 1'b0; Write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        Select = 1'b1; Write = 1'b0; Address = {29'd0, a};
        @(negedge clk);
        Select = 1'b0;
        d = DataOut;
    endtask

    // Drives one frame on rx at 16 clocks per bit, followed by one idle bit.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic use_par,
                              input logic stop);
        rx_drv = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (16) @(negedge clk);
        end
        if (use_par) begin
            rx_drv = pbit;
            repeat (16) @(negedge clk);
        end
        rx_drv = stop;
        repeat (16) @(negedge clk);
        rx_drv = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b expected 1", tx); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b expected 0", irq); end
        tests++; if (DataOut !== 32'h0) begin fails++; $display("FAIL reset_dataout: got %h expected 0", DataOut); end
        rst = 1'b1;
        @(negedge clk);
        bus_read(3'd0, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL reset_ctrl: got %h expected 00000000", v); end
        bus_read(3'd1, v);
        tests++; if (v !== 32'h0000_000A) begin fails++; $display("FAIL reset_status: got %h expected 0000000a", v); end
        bus_read(3'd4, v);
        tests++; if (v !== 32'h0000_1458) begin fails++; $display("FAIL reset_baud: got %h expected 00001458", v); end
    endtask

    task automatic test_regs();
        logic [31:0] v;
        bus_write(3'd4, 32'd2);
        bus_read(3'd4, v);
        tests++; if (v !== 32'd4) begin fails++; $display("FAIL baud_min: got %0d expected 4", v); end
        bus_write(3'd5, 32'hFFFF_FFFF);
        bus_read(3'd5, v);
        tests++; if (v !== 32'd0) begin fails++; $display("FAIL reg5: got %h expected 0", v); end
        bus_read(3'd2, v);
        tests++; if (v !== 32'd0) begin fails++; $display("FAIL txdata_read: got %h expected 0", v); end
        bus_write(3'd4, 32'd16);
        bus_read(3'd4, v);
        tests++; if (v !== 32'd16) begin fails++; $display("FAIL baud_16: got %0d expected 16", v); end
    endtask

    // Sends tx_bytes with tx looped to rx; checks every bit on the line at mid-bit
    // against the frame format, then reads the characters back.
    task automatic run_loopback(input logic [1:0] par, input logic two);
        logic        exp_bits[$];
        logic [31:0] v;
        logic [7:0]  e;
        bit          seen;
        loop = 1'b1;
        bus_write(3'd0, {27'd0, two, par, 2'b10});
        foreach (tx_bytes[k]) bus_write(3'd2, {24'd0, tx_bytes[k]});
        foreach (tx_bytes[k]) begin
            exp_bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) exp_bits.push_back(tx_bytes[k][i]);
            if (par == 2'b01) exp_bits.push_back(^tx_bytes[k]);
            if (par == 2'b10) exp_bits.push_back(~^tx_bytes[k]);
            exp_bits.push_back(1'b1);
            if (two) exp_bits.push_back(1'b1);
            rx_model.push_back(tx_bytes[k]);
        end
        bus_write(3'd0, {27'd0, two, par, 2'b11});
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (tx === 1'b0) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            fails++; $display("FAIL tx_start_timeout: got no start bit expected one within 50 cycles");
        end else begin
            repeat (7) @(negedge clk);
            foreach (exp_bits[i]) begin
                tests++;
                if (tx !== exp_bits[i]) begin
                    fails++; $display("FAIL tx_bit[%0d]: got %b expected %b", i, tx, exp_bits[i]);
                end
                repeat (16) @(negedge clk);
            end
        end
        repeat (24) @(negedge clk);
        while (rx_model.size() > 0) begin
            e = rx_model.pop_front();
            bus_read(3'd3, v);
            tests++; if (v !== {24'd0, e}) begin fails++; $display("FAIL loop_rxdata: got %h expected %h", v, e); end
        end
        bus_read(3'd1, v);
        tests++; if (v[7:0] !== 8'h0A) begin fails++; $display("FAIL loop_status: got %h expected 0a", v[7:0]); end
        tx_bytes.delete();
        loop = 1'b0;
    endtask

    task automatic test_tx_loopback();
        tx_bytes.push_back(8'h5A);
        tx_bytes.push_back(8'hA5);
        run_loopback(2'b00, 1'b0);
    endtask

    task automatic test_random_loopback();
        int n;
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) tx_bytes.push_back(8'($urandom));
            run_loopback(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_errors();
        logic [31:0] v;
        loop = 1'b0;
        rx_drv = 1'b1;
        bus_write(3'd0, 32'h0000_0406);
        send_frame(8'h33, 1'b1, 1'b1, 1'b1);
        bus_read(3'd1, v);
        tests++; if (v[6:5] !== 2'b01) begin fails++; $display("FAIL parity_err: got %b expected 01", v[6:5]); end
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_err: got %b expected 1", irq); end
        bus_read(3'd3, v);
        tests++; if (v !== 32'h33) begin fails++; $display("FAIL parity_data: got %h expected 33", v); end
        send_frame(8'h0F, 1'b0, 1'b1, 1'b0);
        bus_read(3'd1, v);
        tests++; if (v[6] !== 1'b1) begin fails++; $display("FAIL frame_err: got %b expected 1", v[6]); end
        bus_read(3'd3, v);
        tests++; if (v !== 32'h0F) begin fails++; $display("FAIL frame_data: got %h expected 0f", v); end
        bus_write(3'd1, 32'h60);
        bus_read(3'd1, v);
        tests++; if (v[7:5] !== 3'b000) begin fails++; $display("FAIL w1c_clear: got %b expected 000", v[7:5]); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_clear: got %b expected 0", irq); end
    endtask

    task automatic test_overrun();
        logic [31:0] v;
        logic [7:0]  b, e;
        logic        exp_ovr;
        exp_ovr = 1'b0;
        bus_write(3'd0, 32'h2);
        bus_write(3'd1, 32'hE0);
        for (int k = 0; k < 17; k++) begin
            b = 8'($urandom);
            if (rx_model.size() < 16) rx_model.push_back(b);
            else exp_ovr = 1'b1;
            send_frame(b, 1'b0, 1'b0, 1'b1);
        end
        bus_read(3'd1, v);
        tests++; if (v[23:16] !== 8'(rx_model.size())) begin fails++; $display("FAIL ovr_count: got %0d expected %0d", v[23:16], rx_model.size()); end
        tests++; if (v[7] !== exp_ovr) begin fails++; $display("FAIL ovr_flag: got %b expected %b", v[7], exp_ovr); end
        tests++; if (v[2] !== 1'b1) begin fails++; $display("FAIL rx_full: got %b expected 1", v[2]); end
        while (rx_model.size() > 0) begin
            e = rx_model.pop_front();
            bus_read(3'd3, v);
            tests++; if (v !== {24'd0, e}) begin fails++; $display("FAIL ovr_data: got %h expected %h", v, e); end
        end
        bus_read(3'd3, v);
        tests++; if (v !== 32'd0) begin fails++; $display("FAIL empty_read: got %h expected 0", v); end
        bus_read(3'd1, v);
        tests++; if (v[3] !== 1'b1) begin fails++; $display("FAIL rx_empty_after: got %b expected 1", v[3]); end
        bus_write(3'd1, 32'hE0);
    endtask

    task automatic test_tx_full_flush();
        logic [31:0] v;
        int exp_cnt;
        exp_cnt = 0;
        bus_write(3'd0, 32'h0);
        for (int k = 0; k < 17; k++) begin
            bus_write(3'd2, $urandom);
            if (exp_cnt < 16) exp_cnt++;
        end
        bus_read(3'd1, v);
        tests++; if (v[15:8] !== 8'(exp_cnt)) begin fails++; $display("FAIL tx_count: got %0d expected %0d", v[15:8], exp_cnt); end
        tests++; if (v[1:0] !== 2'b01) begin fails++; $display("FAIL tx_full: got %b expected 01", v[1:0]); end
        bus_write(3'd0, 32'h20);
        bus_read(3'd1, v);
        tests++; if (v[15:8] !== 8'd0 || v[1] !== 1'b1) begin fails++; $display("FAIL tx_flush: got count %0d empty %b expected 0 1", v[15:8], v[1]); end
        bus_read(3'd0, v);
        tests++; if (v !== 32'd0) begin fails++; $display("FAIL flush_selfclear: got %h expected 0", v); end
    endtask

    task automatic test_glitch();
        logic [31:0] v;
        bus_write(3'd0, 32'h2);
        rx_drv = 1'b0;
        repeat (2) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        bus_read(3'd1, v);
        tests++; if (v[23:16] !== 8'd0 || v[3] !== 1'b1) begin fails++; $display("FAIL glitch: got rx_count %0d expected 0", v[23:16]); end
        tests++; if (v[7:5] !== 3'b000) begin fails++; $display("FAIL glitch_err: got %b expected 000", v[7:5]); end
    endtask

    task automatic test_midframe_reset();
        logic [31:0] v;
        bit seen;
        bus_write(3'd2, 32'h00);
        bus_write(3'd0, 32'h1);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (tx === 1'b0) seen = 1'b1;
        end
        tests++; if (!seen) begin fails++; $display("FAIL mid_start_timeout: got no start bit expected one"); end
        repeat (23) @(negedge clk);
        tests++; if (tx !== 1'b0) begin fails++; $display("FAIL mid_databit: got %b expected 0", tx); end
        #2 rst = 1'b0;
        #1;
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL mid_reset_tx: got %b expected 1", tx); end
        tests++; if (DataOut !== 32'd0 || irq !== 1'b0) begin fails++; $display("FAIL mid_reset_out: got %h/%b expected 0/0", DataOut, irq); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus_read(3'd0, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL mid_ctrl: got %h expected 0", v); end
        bus_read(3'd1, v);
        tests++; if (v !== 32'h0000_000A) begin fails++; $display("FAIL mid_status: got %h expected 0000000a", v); end
        bus_read(3'd4, v);
        tests++; if (v !== 32'h0000_1458) begin fails++; $display("FAIL mid_baud: got %h expected 00001458", v); end
        repeat (20) @(negedge clk);
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL mid_idle_tx: got %b expected 1", tx); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_tx_loopback();
        test_random_loopback();
        test_errors();
        test_overrun();
        test_tx_full_flush();
        test_glitch();
        bus_write(3'd4, 32'd16);
        test_midframe_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_fifo_mmio.md
Name: uart_fifo_mmio

Overview:
- Memory-mapped full-duplex UART, the parametrised successor of the single-register UART peripheral.
- Adds TX and RX FIFOs of configurable depth, configurable data width, parity mode, stop-bit count, sticky error flags with write-one-to-clear, and a maskable interrupt.
- Sits on the single-cycle core's data bus behind the address decoder (Select/Write/Address/DataIn/DataOut).

Parameters:
- CLK_FREQ, 50_000_000: system clock in Hz.
- BAUD_RATE, 9_600: default baud; reset value of BAUD_DIV = CLK_FREQ/BAUD_RATE.
- DATA_BITS, 8: character width, legal 5..9.
- FIFO_DEPTH, 16: entries per FIFO, power of two, 2..128.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- Address  input  32  word index in Address[2:0]; upper bits ignored.
- DataIn  input  32  write data.
- DataOut  output  32  registered read data.
- Select  input  1  peripheral selected this cycle.
- Write  input  1  1 = write, 0 = read (qualified by Select).
- rx  input  1  serial input, asynchronous to clk.
- tx  output  1  serial output, idle high.
- irq  output  1  level interrupt.

Behaviour:
- Register map (Address[2:0]):
  - 0 CTRL (RW): [0] tx_en; [1] rx_en; [3:2] parity (00 none, 01 even, 10 odd, 11 treated as none); [4] two stop bits; [5] tx_flush; [6] rx_flush (both self-clearing, read 0); [8] ie_rx_nonempty; [9] ie_tx_empty; [10] ie_err.
  - 1 STATUS: [0] tx_full; [1] tx_empty; [2] rx_full; [3] rx_empty; [4] tx_busy (RO); [5] parity_err; [6] frame_err; [7] overrun (sticky, W1C); [15:8] tx_count; [23:16] rx_count (RO); rest 0.
  - 2 TXDATA: write pushes DataIn[DATA_BITS-1:0]; read returns 0.
  - 3 RXDATA: read pops, zero-extended; write ignored.
  - 4 BAUD_DIV (RW): clk cycles per bit. Writes below 4 store 4.
  - 5..7: read 0, write ignored.
- Reset (rst=0, immediate): DataOut=0, tx=1, irq=0, CTRL=0, STATUS sticky bits=0, both FIFOs empty, BAUD_DIV=CLK_FREQ/BAUD_RATE, both FSMs IDLE. Reset mid-frame aborts the frame; tx goes high immediately.
- Bus timing:
  - Reads register DataOut at the edge where Select=1, Write=0.
  - Data is valid the following cycle; read latency is 1.
  - DataOut holds its value when not reading.
  - An RXDATA pop occurs at the same edge.
- Boundary cases:
  - Read of an empty RX FIFO returns 0, no pop.
  - Push to a full TX FIFO is dropped; no flag.
  - Flush empties the FIFO in one cycle and does not abort the frame in flight.
- TX FSM: IDLE -> START -> DATA (DATA_BITS bits, LSB first) -> PARITY (only if enabled) -> STOP (1 or 2 bits) -> IDLE.
  - Leaves IDLE when tx_en=1 and the FIFO is non-empty; the pop happens on that transition.
  - Each state lasts BAUD_DIV cycles.
  - CTRL and BAUD_DIV are latched at frame start; mid-frame changes apply to the next frame.
  - tx_busy=1 when not in IDLE.
  - Back-to-back frames have no idle gap.
- RX path:
  - rx passes through a 2-flop synchronizer.
  - In IDLE with rx_en=1, a falling edge starts a count of BAUD_DIV/2. START re-samples rx: if high, the event is a glitch and the FSM returns to IDLE; otherwise continue.
  - Each data, parity and stop bit is sampled at BAUD_DIV intervals. Only one stop bit is checked regardless of CTRL[4].
  - On completion the character is pushed.
  - Parity mismatch sets parity_err; stop sampled low sets frame_err. The character is still pushed.
  - If the FIFO is full at completion, the character is dropped and overrun is set.
  - Clearing rx_en mid-frame completes the current frame.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle leave the count unchanged.
  - A hardware set and a W1C of the same sticky bit in one cycle: set wins.
- irq = (ie_rx_nonempty & !rx_empty) | (ie_tx_empty & tx_empty & !tx_busy) | (ie_err & |STATUS[7:5]); registered.

Test Plan:
- Reset defaults: release rst, read regs 0,1,4 -> 0x0, 0x0000000A, 0x1458 (tx_empty=1, rx_empty=1; 50M/9600=5208); tx=1.
- TX loopback:
  - Setup: BAUD_DIV=16, CTRL=0x3, rx tied to tx; write TXDATA 0x5A, then 0xA5.
  - tx shows start/0,1,0,1,1,0,1,0/stop with each bit 16 cycles.
  - Read RXDATA twice -> 0x5A, 0xA5; rx_empty=1 after.
- Parity and frame errors:
  - With even parity, drive a frame with a wrong parity bit -> STATUS[5]=1, data pushed.
  - Drive a stop bit low -> STATUS[6]=1.
  - Write STATUS 0x60 -> both bits clear.
- RX overrun: DEPTH=16 with 17 frames sent and no reads -> rx_count=16, overrun=1, the first 16 bytes are read back intact, and the 17th is lost.
- TX full and flush: tx_en=0 with 17 pushes -> tx_count=16, tx_full=1; write CTRL bit5 -> tx_count=0, tx_empty=1.
- Glitch and mid-frame reset:
  - A 2-cycle low pulse on rx -> no push.
  - Assert rst during a TX data bit -> tx=1 immediately, and all reset values are restored.
